// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants and FSM state encoding for the memory-access stage
package mem_access_pkg;

  localparam int WORD_W = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - execute, data-memory and writeback signal bundle for mem_access
interface mem_access_if;
  import mem_access_pkg::*;

  logic                  in_valid;
  logic                  rd_write_enable_in;
  logic [REG_ADDR_W-1:0] rd_write_addr_in;
  logic                  res_src_in;
  logic                  mem_write_enable_in;
  logic [WORD_W-1:0]     exec_in;
  logic [WORD_W-1:0]     mem_write_data_in;
  logic [WORD_W-1:0]     next_pc_in;
  logic                  stall;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [WORD_W-1:0]     dmem_addr;
  logic [WORD_W-1:0]     dmem_wdata;
  logic [WORD_W-1:0]     dmem_rdata;
  logic                  dmem_ack;

  logic                  wb_valid;
  logic                  rd_write_enable_out;
  logic [REG_ADDR_W-1:0] rd_write_addr_out;
  logic                  res_src_out;
  logic [WORD_W-1:0]     exec_out;
  logic [WORD_W-1:0]     mem_rdata_out;
  logic [WORD_W-1:0]     next_pc_out;
  logic                  misalign_out;

  modport slave (
    input  in_valid, rd_write_enable_in, rd_write_addr_in, res_src_in,
           mem_write_enable_in, exec_in, mem_write_data_in, next_pc_in,
           dmem_rdata, dmem_ack,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, rd_write_enable_out, rd_write_addr_out, res_src_out,
           exec_out, mem_rdata_out, next_pc_out, misalign_out
  );

  modport master (
    output in_valid, rd_write_enable_in, rd_write_addr_in, res_src_in,
           mem_write_enable_in, exec_in, mem_write_data_in, next_pc_in,
           dmem_rdata, dmem_ack,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, rd_write_enable_out, rd_write_addr_out, res_src_out,
           exec_out, mem_rdata_out, next_pc_out, misalign_out
  );

endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory-access stage: ALU pass-through, load/store via data-memory handshake
// Optional MEM_ALIGN_CHECK_EN: misaligned memory ops retire at once with misalign_out instead of accessing memory.
module mem_access
  import mem_access_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
);

  state_t state, state_next;
  logic   accept, retire, direct, mem_op, misalign;

  logic                  lat_rd_we, lat_res_src, lat_mem_we;
  logic [REG_ADDR_W-1:0] lat_rd;
  logic [WORD_W-1:0]     lat_exec, lat_wdata, lat_npc;

  logic                  src_rd_we, src_res_src, src_load;
  logic [REG_ADDR_W-1:0] src_rd;
  logic [WORD_W-1:0]     src_exec, src_npc;

  logic                  wb_valid_q, rd_we_q, res_src_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [WORD_W-1:0]     exec_q, rdata_q, npc_q;

  assign mem_op = bus.res_src_in | bus.mem_write_enable_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (bus.exec_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    retire     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          if (mem_op && !misalign) state_next = ST_ACCESS;
          else                     retire     = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (bus.dmem_ack) begin
          retire     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Ops retiring straight from IDLE take their fields from the inputs, others from the latch.
  assign direct      = (state == ST_IDLE);
  assign src_rd_we   = direct ? (bus.rd_write_enable_in & ~misalign) : lat_rd_we;
  assign src_rd      = direct ? bus.rd_write_addr_in : lat_rd;
  assign src_res_src = direct ? bus.res_src_in : lat_res_src;
  assign src_exec    = direct ? bus.exec_in : lat_exec;
  assign src_npc     = direct ? bus.next_pc_in : lat_npc;
  assign src_load    = ~direct & lat_res_src & ~lat_mem_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rd_we   <= 1'b0;
      lat_res_src <= 1'b0;
      lat_mem_we  <= 1'b0;
      lat_rd      <= '0;
      lat_exec    <= '0;
      lat_wdata   <= '0;
      lat_npc     <= '0;
    end else if (accept) begin
      lat_rd_we   <= bus.rd_write_enable_in;
      lat_res_src <= bus.res_src_in;
      lat_mem_we  <= bus.mem_write_enable_in;
      lat_rd      <= bus.rd_write_addr_in;
      lat_exec    <= bus.exec_in;
      lat_wdata   <= bus.mem_write_data_in;
      lat_npc     <= bus.next_pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      rd_we_q    <= 1'b0;
      res_src_q  <= 1'b0;
      rd_q       <= '0;
      exec_q     <= '0;
      rdata_q    <= '0;
      npc_q      <= '0;
    end else begin
      wb_valid_q <= retire;
      rd_we_q    <= retire & src_rd_we;
      if (retire) begin
        res_src_q <= src_res_src;
        rd_q      <= src_rd;
        exec_q    <= src_exec;
        npc_q     <= src_npc;
        rdata_q   <= src_load ? bus.dmem_rdata : '0;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      misalign_q <= 1'b0;
    else if (retire) misalign_q <= direct & misalign;
  end
  assign bus.misalign_out = misalign_q;
  assign bus.dmem_addr    = lat_exec;
`else
  assign bus.misalign_out = 1'b0;
  assign bus.dmem_addr    = {lat_exec[WORD_W-1:2], 2'b00};
`endif

  assign bus.stall      = (state == ST_ACCESS);
  assign bus.dmem_req   = (state == ST_ACCESS);
  assign bus.dmem_we    = (state == ST_ACCESS) & lat_mem_we;
  assign bus.dmem_wdata = lat_wdata;

  assign bus.wb_valid            = wb_valid_q;
  assign bus.rd_write_enable_out = rd_we_q;
  assign bus.rd_write_addr_out   = rd_q;
  assign bus.res_src_out         = res_src_q;
  assign bus.exec_out            = exec_q;
  assign bus.mem_rdata_out       = rdata_q;
  assign bus.next_pc_out         = npc_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access with a retirement-queue model
module tb_mem_access;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  mem_access_if bus();

  mem_access dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_we;
    logic [4:0]  rd;
    logic        res_src;
    logic [31:0] exec;
    logic [31:0] rdata;
    logic [31:0] npc;
    logic        mis;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic rwe, input logic [4:0] rd, input logic rs,
                       input logic mwe, input logic [31:0] ex, input logic [31:0] wd,
                       input logic [31:0] npc);
    bus.in_valid            = v;
    bus.rd_write_enable_in  = rwe;
    bus.rd_write_addr_in    = rd;
    bus.res_src_in          = rs;
    bus.mem_write_enable_in = mwe;
    bus.exec_in             = ex;
    bus.mem_write_data_in   = wd;
    bus.next_pc_in          = npc;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Every retirement the DUT reports must match the oldest expected op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wb_valid) begin
          if (q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            check("wb_rd_we", bus.rd_write_enable_out, e.rd_we);
            check("wb_rd", bus.rd_write_addr_out, e.rd);
            check("wb_res_src", bus.res_src_out, e.res_src);
            check("wb_exec", bus.exec_out, e.exec);
            check("wb_rdata", bus.mem_rdata_out, e.rdata);
            check("wb_npc", bus.next_pc_out, e.npc);
            check("wb_misalign", bus.misalign_out, e.mis);
          end
        end else begin
          check("rd_we_gated", bus.rd_write_enable_out, 32'd0);
        end
      end
    end
  end

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] ex, input logic [31:0] npc);
    check("alu_idle_before", bus.stall, 32'd0);
    drive(1'b1, 1'b1, rd, 1'b0, 1'b0, ex, 32'h0, npc);
    q.push_back('{rd_we: 1'b1, rd: rd, res_src: 1'b0, exec: ex, rdata: 32'h0, npc: npc, mis: 1'b0});
    @(negedge clk);
    idle_in();
    check("alu_wb_next", bus.wb_valid, 32'd1);
    check("alu_no_req", bus.dmem_req, 32'd0);
    check("alu_no_stall", bus.stall, 32'd0);
  endtask

  // n = ACCESS cycles up to and including the ack cycle; junk offers a new op during ACCESS.
  task automatic mem_op(input bit st, input bit both, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int n, input logic [4:0] rd,
                        input logic [31:0] npc, input bit junk);
    logic [31:0] ea;
    logic        rs;
    ea = {addr[31:2], 2'b00};
    rs = !st || both;
    check("mem_idle_before", bus.stall, 32'd0);
    drive(1'b1, !st, rd, rs, st, addr, wd, npc);
    q.push_back('{rd_we: !st, rd: rd, res_src: rs, exec: addr,
                  rdata: st ? 32'h0 : rdat, npc: npc, mis: 1'b0});
    @(negedge clk);
    if (junk) drive(1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'hEEEE_0000);
    else idle_in();
    for (int i = 1; i <= n; i++) begin
      check("acc_req", bus.dmem_req, 32'd1);
      check("acc_stall", bus.stall, 32'd1);
      check("acc_addr", bus.dmem_addr, ea);
      check("acc_we", bus.dmem_we, {31'd0, st});
      if (st) check("acc_wdata", bus.dmem_wdata, wd);
      check("acc_no_wb", bus.wb_valid, 32'd0);
      if (i == n) begin
        idle_in();
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdat;
      end
      @(negedge clk);
    end
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'hBAD0_BAD0;
    check("mem_latency_wb", bus.wb_valid, 32'd1);
    check("mem_done_stall", bus.stall, 32'd0);
    check("mem_done_req", bus.dmem_req, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_in();
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", bus.wb_valid, 32'd0);
    check("rst_req", bus.dmem_req, 32'd0);
    check("rst_stall", bus.stall, 32'd0);
    check("rst_exec_out", bus.exec_out, 32'd0);
    check("rst_rdata_out", bus.mem_rdata_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_wb", bus.wb_valid, 32'd0);

    alu_op(5'd5, 32'h0000_002A, 32'h0000_1004);
    check("add_exec_lit", bus.exec_out, 32'h0000_002A);
    check("add_rd_lit", bus.rd_write_addr_out, 32'd5);

    mem_op(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 5'd7, 32'h1008, 1'b0);
    check("load_rdata_lit", bus.mem_rdata_out, 32'hDEAD_BEEF);

    mem_op(1'b1, 1'b0, 32'h200, 32'h1234_5678, 32'h1111_1111, 1, 5'd0, 32'h100C, 1'b0);
    @(negedge clk);
    check("store_single_pulse", bus.wb_valid, 32'd0);
    check("store_rdata_zero", bus.mem_rdata_out, 32'd0);

    mem_op(1'b1, 1'b1, 32'h204, 32'hA5A5_5A5A, 32'h2222_2222, 3, 5'd0, 32'h1010, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
    drive(1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 32'h102, 32'h0, 32'h1014);
    q.push_back('{rd_we: 1'b0, rd: 5'd6, res_src: 1'b1, exec: 32'h102, rdata: 32'h0,
                  npc: 32'h1014, mis: 1'b1});
    @(negedge clk);
    idle_in();
    check("mis_wb", bus.wb_valid, 32'd1);
    check("mis_flag", bus.misalign_out, 32'd1);
    check("mis_no_req", bus.dmem_req, 32'd0);
`else
    mem_op(1'b0, 1'b0, 32'h102, 32'h0, 32'hCAFE_F00D, 1, 5'd6, 32'h1014, 1'b0);
    check("mis_addr_lit", bus.dmem_addr, 32'h100);
    check("mis_flag_tied", bus.misalign_out, 32'd0);
`endif

    mem_op(1'b0, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, 2, 5'd8, 32'h1018, 1'b0);
    alu_op(5'd9, 32'h0000_0077, 32'h101C);

    bus.dmem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack_ignored", bus.wb_valid, 32'd0);
      check("idle_ack_stall", bus.stall, 32'd0);
    end
    bus.dmem_ack = 1'b0;

    drive(1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 32'h400, 32'h0, 32'h1020);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    check("rmid_req_before", bus.dmem_req, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_req_async", bus.dmem_req, 32'd0);
    check("rmid_stall_async", bus.stall, 32'd0);
    check("rmid_exec_clr", bus.exec_out, 32'd0);
    check("rmid_addr_clr", bus.dmem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge clk);
      check("rmid_no_retire", bus.wb_valid, 32'd0);
    end
    bus.dmem_ack = 1'b0;

    alu_op(5'd12, 32'h0000_0055, 32'h1024);
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
